// File: rtl/rv_alu_pkg.sv
// rv_alu_pkg: shared ALU op/state enums, funct3 encodings and the funct3/alt/is_imm decoder
package rv_alu_pkg;
  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_e;
  // alt only selects SUB for register-register ops; immediates never subtract.
  function automatic alu_op_e decode(input logic [2:0] funct3, input logic alt, input logic is_imm);
    case (funct3)
      FUNCT3_ADD:  return (alt && !is_imm) ? ALU_SUB : ALU_ADD;
      FUNCT3_SLL:  return ALU_SLL;
      FUNCT3_SLT:  return ALU_SLT;
      FUNCT3_SLTU: return ALU_SLTU;
      FUNCT3_XOR:  return ALU_XOR;
      FUNCT3_SR:   return alt ? ALU_SRA : ALU_SRL;
      FUNCT3_OR:   return ALU_OR;
      default:     return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/rv_shift_step.sv
// rv_shift_step: one combinational shift iteration of acc by k positions (left, logical or arithmetic right)
//   acc_i   value to shift          k_i    shift distance (never above the step size)
//   left_i  1 = shift left          arith_i 1 = arithmetic right (sign fill)
//   res_o   shifted value
module rv_shift_step #(
  parameter int XLEN = 32,
  parameter int KW   = 6
) (
  input  logic [XLEN-1:0] acc_i,
  input  logic [KW-1:0]   k_i,
  input  logic            left_i,
  input  logic            arith_i,
  output logic [XLEN-1:0] res_o
);
  logic [XLEN-1:0] sra;
  // The accumulator keeps the original sign bit across every arithmetic step,
  // so a signed shift here fills with the original rs1 MSB.
  assign sra = $unsigned($signed(acc_i) >>> k_i);
  assign res_o = left_i ? acc_i << k_i : arith_i ? sra : acc_i >> k_i;
endmodule

// File: rtl/rv_alu_iter.sv
// rv_alu_iter: handshaked RV32I/RV64I OP/OP-IMM ALU with single-cycle logic/arith and iterative shifts
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          operation handshake; in_funct3, in_alt, in_is_imm, in_rs1, in_rs2, in_imm
//   flush                      synchronous abort of any in-flight op
//   out_valid/out_ready        result handshake; out_result
module rv_alu_iter
  import rv_alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  parameter int SHAMT_W    = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_alt,
  input  logic            in_is_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [11:0]     in_imm,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);
  localparam logic [SHAMT_W:0] STEP = (SHAMT_W+1)'(SHIFT_STEP);
  alu_state_e state_q, state_d;
  alu_op_e op, op_q, op_d;
  logic [XLEN-1:0] b, alu_res, sh_res, acc_q, acc_d;
  logic [SHAMT_W-1:0] shamt, rem_q, rem_d;
  logic [SHAMT_W:0] k;
  logic accept, is_shift;
  assign b = in_is_imm ? {{(XLEN-12){in_imm[11]}}, in_imm} : in_rs2;
  assign shamt = b[SHAMT_W-1:0];
  assign op = decode(in_funct3, in_alt, in_is_imm);
  assign is_shift = op inside {ALU_SLL, ALU_SRL, ALU_SRA};
  assign in_ready = rst_n & !flush & (state_q == IDLE | (state_q == DONE & out_ready));
  assign accept = in_valid & in_ready;
  assign out_valid = state_q == DONE & !flush;
  assign out_result = acc_q;
  // Last iteration may cover fewer than SHIFT_STEP positions.
  assign k = {1'b0, rem_q} < STEP ? {1'b0, rem_q} : STEP;
  always_comb begin
    alu_res = in_rs1;
    case (op)
      ALU_ADD:  alu_res = in_rs1 + b;
      ALU_SUB:  alu_res = in_rs1 - b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(in_rs1) < $signed(b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, in_rs1 < b};
      ALU_XOR:  alu_res = in_rs1 ^ b;
      ALU_OR:   alu_res = in_rs1 | b;
      ALU_AND:  alu_res = in_rs1 & b;
      default:  alu_res = in_rs1;
    endcase
  end
  rv_shift_step #(.XLEN(XLEN), .KW(SHAMT_W+1)) u_shift (
    .acc_i  (acc_q),
    .k_i    (k),
    .left_i (op_q == ALU_SLL),
    .arith_i(op_q == ALU_SRA),
    .res_o  (sh_res)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    acc_d = acc_q;
    rem_d = rem_q;
    if (flush) state_d = IDLE;
    else if (accept) begin
      op_d = op;
      acc_d = alu_res;
      rem_d = shamt;
      state_d = (is_shift && shamt != '0) ? SHIFT : DONE;
    end else if (state_q == SHIFT) begin
      acc_d = sh_res;
      rem_d = rem_q - k[SHAMT_W-1:0];
      state_d = {1'b0, rem_q} == k ? DONE : SHIFT;
    end else if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= ALU_ADD;
      acc_q <= '0;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      acc_q <= acc_d;
      rem_q <= rem_d;
    end
  end
endmodule

// File: tb/tb_rv_alu_iter.sv
// tb_rv_alu_iter: directed checks of rv_alu_iter in 32-bit/step1, 32-bit/step8 and 64-bit/step1 builds
module tb_rv_alu_iter;
  logic clk = 0, rst_n = 0, flush = 0, ordy = 1;
  logic [2:0] iv = '0, f3 = '0;
  logic alt = 0, isimm = 0;
  logic [63:0] rs1 = '0, rs2 = '0;
  logic [11:0] imm = '0;
  wire [2:0] ir, ov;
  logic [31:0] r32, r8;
  logic [63:0] r64;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  rv_alu_iter #(.XLEN(32), .SHIFT_STEP(1)) d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_funct3(f3), .in_alt(alt),
    .in_is_imm(isimm), .in_rs1(rs1[31:0]), .in_rs2(rs2[31:0]), .in_imm(imm), .flush(flush),
    .out_valid(ov[0]), .out_ready(ordy), .out_result(r32));
  rv_alu_iter #(.XLEN(32), .SHIFT_STEP(8)) d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_funct3(f3), .in_alt(alt),
    .in_is_imm(isimm), .in_rs1(rs1[31:0]), .in_rs2(rs2[31:0]), .in_imm(imm), .flush(flush),
    .out_valid(ov[1]), .out_ready(ordy), .out_result(r8));
  rv_alu_iter #(.XLEN(64), .SHIFT_STEP(1)) d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_funct3(f3), .in_alt(alt),
    .in_is_imm(isimm), .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm), .flush(flush),
    .out_valid(ov[2]), .out_ready(ordy), .out_result(r64));
  function automatic logic [63:0] res_of(input int s);
    return s == 0 ? {32'h0, r32} : s == 1 ? {32'h0, r8} : r64;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic setop(input logic [2:0] f, input logic a, input logic im,
                       input logic [63:0] a1, input logic [63:0] a2, input logic [11:0] i);
    f3 = f; alt = a; isimm = im; rs1 = a1; rs2 = a2; imm = i;
  endtask
  task automatic run(input string tag, input int s, input logic [2:0] f, input logic a, input logic im,
                     input logic [63:0] a1, input logic [63:0] a2, input logic [11:0] i,
                     input logic [63:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    setop(f, a, im, a1, a2, i);
    iv[s] = 1;
    @(posedge clk);
    #1 iv[s] = 0;
    lat = 1;
    while (!ov[s] && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    check(tag, res_of(s), exp);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask
  initial begin
    int seen;
    #3;
    check("rst_valid", 64'(ov[0]), 0);
    check("rst_ready", 64'(ir[0]), 0);
    check("rst_result", {32'h0, r32}, 0);
    @(negedge clk) rst_n = 1;
    run("addi", 0, 3'b000, 0, 1, 5, 0, 12'hFFD, 64'h2, 1);
    run("sltiu_ones", 0, 3'b011, 0, 1, 5, 0, 12'hFFF, 64'h1, 1);
    run("slti_neg", 0, 3'b010, 0, 1, 5, 0, 12'hFFF, 64'h0, 1);
    run("sub", 0, 3'b000, 1, 0, 3, 5, 0, 64'hFFFF_FFFE, 1);
    run("addi_alt", 0, 3'b000, 1, 1, 3, 0, 12'h005, 64'h8, 1);
    run("slt_reg", 0, 3'b010, 0, 0, 64'hFFFF_FFFF, 1, 0, 64'h1, 1);
    run("sltu_reg", 0, 3'b011, 0, 0, 64'hFFFF_FFFF, 1, 0, 64'h0, 1);
    run("and_reg", 0, 3'b111, 0, 0, 64'hFF0F, 64'h0FF0, 0, 64'h0F00, 1);
    run("xori_neg", 0, 3'b100, 0, 1, 64'hFF, 0, 12'hFFF, 64'hFFFF_FF00, 1);
    run("srai31", 0, 3'b101, 1, 1, 64'h8000_0000, 0, 12'h41F, 64'hFFFF_FFFF, 32);
    run("srli31", 0, 3'b101, 0, 1, 64'h8000_0000, 0, 12'h01F, 64'h1, 32);
    run("slli4", 0, 3'b001, 0, 1, 64'h1, 0, 12'h004, 64'h10, 5);
    run("sra_reg", 0, 3'b101, 1, 0, 64'h8000_0000, 64'h24, 0, 64'hF800_0000, 5);
    run("srai0", 0, 3'b101, 1, 1, 64'h1234_5678, 0, 12'h400, 64'h1234_5678, 1);
    run("s8_srai31", 1, 3'b101, 1, 1, 64'h8000_0000, 0, 12'h41F, 64'hFFFF_FFFF, 5);
    run("s8_slli8", 1, 3'b001, 0, 1, 64'h1, 0, 12'h008, 64'h100, 2);
    run("s8_srli0", 1, 3'b101, 0, 1, 64'hABCD, 0, 12'h000, 64'hABCD, 1);
    run("x64_slli63", 2, 3'b001, 0, 1, 64'h1, 0, 12'h03F, 64'h8000_0000_0000_0000, 64);
    run("x64_addi_wrap", 2, 3'b000, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 12'h001, 64'h0, 1);
    run("x64_sltiu", 2, 3'b011, 0, 1, 64'h5, 0, 12'hFFF, 64'h1, 1);
    @(negedge clk);
    ordy = 0;
    setop(3'b000, 0, 0, 1, 2, 0);
    iv[0] = 1;
    @(posedge clk);
    #1 iv[0] = 0;
    check("hold_valid0", 64'(ov[0]), 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold_result", {32'h0, r32}, 64'h3);
      check("hold_valid", 64'(ov[0]), 1);
      check("hold_ready", 64'(ir[0]), 0);
    end
    @(negedge clk);
    setop(3'b100, 0, 1, 64'hAA, 0, 12'h0FF);
    iv[0] = 1;
    ordy = 1;
    #1 check("b2b_ready", 64'(ir[0]), 1);
    @(posedge clk);
    #1 iv[0] = 0;
    check("b2b_valid", 64'(ov[0]), 1);
    check("b2b_result", {32'h0, r32}, 64'h55);
    @(negedge clk);
    setop(3'b101, 0, 1, 64'hFFFF_0000, 0, 12'h014);
    iv[0] = 1;
    @(posedge clk);
    #1 iv[0] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1;
    #1 check("flush_ready", 64'(ir[0]), 0);
    check("flush_valid", 64'(ov[0]), 0);
    @(posedge clk);
    #1 flush = 0;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1 if (ov[0]) seen = 1;
    end
    check("flush_no_valid", 64'(seen), 0);
    run("ori_after_flush", 0, 3'b110, 0, 1, 64'hF0, 0, 12'h00F, 64'hFF, 1);
    @(negedge clk);
    setop(3'b101, 0, 1, 64'hFFFF_0000, 0, 12'h014);
    iv[0] = 1;
    @(posedge clk);
    #1 iv[0] = 0;
    repeat (4) @(posedge clk);
    #2 rst_n = 0;
    #1 check("rst_mid_ready", 64'(ir[0]), 0);
    check("rst_mid_result", {32'h0, r32}, 0);
    @(negedge clk) rst_n = 1;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1 if (ov[0]) seen = 1;
    end
    check("rst_no_valid", 64'(seen), 0);
    run("ori_after_rst", 0, 3'b110, 0, 1, 64'hF0, 0, 12'h00F, 64'hFF, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
